tmds_symbol_decoder: RTL and testbench



---
 rtl/tmds_symbol_decoder_if.sv | 19 +
 rtl/tmds_symbol_decoder.sv | 149 ++++++++++++++
 tb/tb_tmds_symbol_decoder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_symbol_decoder_if.sv
// Parallel symbol bus of one TMDS receive channel.
//   in_word  : raw 10-bit deserialized word, in_word[0] received first
//   out_data : decoded pixel byte
//   out_c    : decoded control value {c1,c0}
//   out_de   : 1 = data symbol, 0 = control token
//   locked   : symbol alignment locked
//   offset   : bit offset of the symbol boundary inside the word pair, 0..9
// master = word source / sink of decoded symbols, slave = decoder.
interface tmds_symbol_decoder_if;
   logic [9:0] in_word;
   logic [7:0] out_data;
   logic [1:0] out_c;
   logic       out_de;
   logic       locked;
   logic [3:0] offset;

   modport master (output in_word, input out_data, out_c, out_de, locked, offset);
   modport slave  (input in_word, output out_data, out_c, out_de, locked, offset);
endinterface

// File: rtl/tmds_symbol_decoder.sv
// TMDS receive decoder for one channel: finds the symbol boundary in an
// arbitrarily aligned 10-bit word stream using runs of DVI control tokens,
// tracks lock, and decodes aligned symbols to pixel bytes or control values.
//   clk_pixel : pixel clock, all logic on rising edge
//   resetn    : asynchronous active-low reset
//   bus       : slave side of tmds_symbol_decoder_if (in_word in, decoded symbol
//               plus locked/offset out)
module tmds_symbol_decoder #(
   parameter int unsigned C_min_run       = 8,
   parameter int unsigned C_search_window = 4096
) (
   input logic                  clk_pixel,
   input logic                  resetn,
   tmds_symbol_decoder_if.slave bus
);

   localparam int unsigned TIMER_W = $clog2(C_search_window);
   localparam int unsigned RUN_W   = $clog2(C_min_run + 1);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] CONFIRM = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam logic [9:0] TOK_C00 = 10'b1101010100;
   localparam logic [9:0] TOK_C01 = 10'b0010101011;
   localparam logic [9:0] TOK_C10 = 10'b0101010100;
   localparam logic [9:0] TOK_C11 = 10'b1010101011;

   logic [9:0]         prev_word;
   logic [9:0]         w;
   logic [9:0]         w_next;
   logic [19:0]        pair;
   logic [3:0]         offset_q;
   logic [3:0]         offset_next;
   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [RUN_W-1:0]   run_cnt;
   logic [RUN_W-1:0]   run_next;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   logic               is_tok;
   logic [1:0]         tok_c;
   logic               run_event;
   logic               expiry;
   logic [7:0]         d;
   logic [7:0]         x;
   logic [7:0]         dec;
   logic [7:0]         out_data_q;
   logic [1:0]         out_c_q;
   logic               out_de_q;
   logic               locked_q;

   // Token classification, run/timer bookkeeping, alignment FSM and decode
   always_comb begin
      is_tok      = 1'b1;
      tok_c       = 2'b00;
      state_next  = state;
      offset_next = offset_q;

      case (w)
         TOK_C00: tok_c = 2'b00;
         TOK_C01: tok_c = 2'b01;
         TOK_C10: tok_c = 2'b10;
         TOK_C11: tok_c = 2'b11;
         default: is_tok = 1'b0;
      endcase

      // A run event is the single cycle the run count reaches C_min_run, so a
      // new event always implies the count dropped since the previous one.
      run_event = is_tok && (run_cnt == RUN_W'(C_min_run - 1));
      expiry    = (timer == TIMER_W'(C_search_window - 1));

      if (!is_tok)
         run_next = '0;
      else if (run_cnt == RUN_W'(C_min_run))
         run_next = run_cnt;
      else
         run_next = run_cnt + RUN_W'(1);

      timer_next = timer + TIMER_W'(1);

      // Run event takes priority over a simultaneous timer expiry
      if (run_event) begin
         timer_next = '0;
         case (state)
            SEARCH:  state_next = CONFIRM;
            CONFIRM: state_next = LOCKED;
            default: state_next = state;
         endcase
      end else if (expiry) begin
         timer_next  = '0;
         run_next    = '0;
         state_next  = SEARCH;
         offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      end

      // Window of 10 serial bits starting offset bits into the older word
      pair   = {bus.in_word, prev_word};
      w_next = 10'(pair >> offset_q);

      // Undo optional inversion, then undo the XOR/XNOR transition chain
      d   = w[9] ? ~w[7:0] : w[7:0];
      x   = d ^ {d[6:0], 1'b0};
      dec = w[8] ? {x[7:1], d[0]} : {~x[7:1], d[0]};
   end

   // Pipeline, alignment state and registered outputs
   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         prev_word  <= '0;
         w          <= '0;
         offset_q   <= '0;
         state      <= SEARCH;
         run_cnt    <= '0;
         timer      <= '0;
         out_data_q <= '0;
         out_c_q    <= '0;
         out_de_q   <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         prev_word <= bus.in_word;
         w         <= w_next;
         offset_q  <= offset_next;
         state     <= state_next;
         run_cnt   <= run_next;
         timer     <= timer_next;
         locked_q  <= (state == LOCKED);
         if (state != LOCKED) begin
            out_data_q <= '0;
            out_c_q    <= '0;
            out_de_q   <= 1'b0;
         end else if (is_tok) begin
            out_data_q <= '0;
            out_c_q    <= tok_c;
            out_de_q   <= 1'b0;
         end else begin
            out_data_q <= dec;
            out_de_q   <= 1'b1;
         end
      end
   end

   assign bus.out_data = out_data_q;
   assign bus.out_c    = out_c_q;
   assign bus.out_de   = out_de_q;
   assign bus.locked   = locked_q;
   assign bus.offset   = offset_q;

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Bench for tmds_symbol_decoder: a serial-stream generator with selectable bit
// delay feeds video lines (data + control-token blanking); a behavioural model
// working on the bit stream predicts alignment, lock and decoded symbols.
module tb_tmds_symbol_decoder;

   localparam int unsigned C_MIN_RUN = 8;
   localparam int unsigned C_WIN     = 4096;
   localparam int          LINE_DATA = 1280;
   localparam int          LINE_LEN  = 1650;

   logic clk_pixel = 1'b0;
   logic resetn;

   tmds_symbol_decoder_if bus ();

   tmds_symbol_decoder #(
      .C_min_run       (C_MIN_RUN),
      .C_search_window (C_WIN)
   ) dut (
      .clk_pixel (clk_pixel),
      .resetn    (resetn),
      .bus       (bus)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_SEARCH, M_CONFIRM, M_LOCKED} mstate_t;

   logic [9:0] toks [4];
   logic [7:0] dec_tab [512];
   mstate_t    m_state;
   int         m_off;
   int         m_since;
   int         m_run_len;
   logic [9:0] m_prev;
   logic [9:0] m_win;
   logic [7:0] e_data;
   logic [1:0] e_c;
   logic       e_de;
   logic       e_locked;

   function automatic int token_class(input logic [9:0] s);
      for (int k = 0; k < 4; k++)
         if (s == toks[k]) return k;
      return -1;
   endfunction

   // Forward TMDS transition-minimising encode with chosen mode and inversion
   function automatic logic [9:0] encode_byte(input logic [7:0] b, input logic xm, input logic inv);
      logic [7:0] q;
      q[0] = b[0];
      for (int i = 1; i < 8; i++)
         q[i] = xm ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
      return {inv, xm, inv ? ~q : q};
   endfunction

   function automatic logic [7:0] model_decode(input logic [9:0] s);
      logic [7:0] q;
      q = s[9] ? ~s[7:0] : s[7:0];
      return dec_tab[{s[8], q}];
   endfunction

   task automatic model_reset();
      m_state   = M_SEARCH;
      m_off     = 0;
      m_since   = 0;
      m_run_len = 0;
      m_prev    = '0;
      m_win     = '0;
      e_data    = '0;
      e_c       = '0;
      e_de      = 1'b0;
      e_locked  = 1'b0;
   endtask

   // One pixel clock of the model; word is what the decoder samples this edge
   task automatic model_step(input logic [9:0] word);
      int          cls;
      logic        tok;
      logic        ev;
      logic        expire;
      logic [19:0] pair;
      cls    = token_class(m_win);
      tok    = (cls >= 0);
      ev     = tok && (m_run_len + 1 == int'(C_MIN_RUN));
      expire = (m_since == int'(C_WIN) - 1);

      e_locked = (m_state == M_LOCKED);
      if (m_state != M_LOCKED) begin
         e_de = 1'b0; e_c = 2'b00; e_data = 8'h00;
      end else if (tok) begin
         e_de = 1'b0; e_c = 2'(cls); e_data = 8'h00;
      end else begin
         e_de = 1'b1; e_data = model_decode(m_win);
      end

      pair   = {word, m_prev};
      m_win  = 10'(pair >> m_off);
      m_prev = word;

      m_run_len = tok ? m_run_len + 1 : 0;
      if (ev) begin
         m_since = 0;
         if (m_state == M_SEARCH)       m_state = M_CONFIRM;
         else if (m_state == M_CONFIRM) m_state = M_LOCKED;
      end else if (expire) begin
         m_since   = 0;
         m_run_len = 0;
         m_state   = M_SEARCH;
         m_off     = (m_off + 1) % 10;
      end else begin
         m_since++;
      end
   endtask

   // ---------------- stream generator ----------------
   int         g_pos;
   int         g_shift;
   logic [9:0] g_last;
   logic       g_rand_data;
   logic       g_rand_tok;
   logic       g_data_only;

   task automatic start_stream(input int shift, input logic rdata, input logic rtok, input logic donly);
      g_pos       = 0;
      g_shift     = shift;
      g_rand_data = rdata;
      g_rand_tok  = rtok;
      g_data_only = donly;
   endtask

   task automatic next_word(output logic [9:0] word);
      logic [9:0]  sym;
      logic [19:0] pair;
      if (g_data_only || g_pos < LINE_DATA) begin
         if (g_rand_data) begin
            do sym = encode_byte(8'($urandom), 1'($urandom), 1'($urandom));
            while (token_class(sym) >= 0);
         end else begin
            sym = 10'h100;
         end
      end else begin
         sym = g_rand_tok ? toks[$urandom_range(3)] : toks[0];
      end
      g_pos  = (g_pos + 1) % LINE_LEN;
      pair   = {sym, g_last};
      word   = 10'(pair >> (10 - g_shift));
      g_last = sym;
   endtask

   // ---------------- clocking helpers ----------------
   task automatic tick(input logic [9:0] word);
      bus.in_word = word;
      @(posedge clk_pixel);
      if (resetn) model_step(word);
      @(negedge clk_pixel);
      check("locked",   32'(bus.locked),   32'(e_locked));
      check("offset",   32'(bus.offset),   32'(m_off));
      check("out_de",   32'(bus.out_de),   32'(e_de));
      check("out_c",    32'(bus.out_c),    32'(e_c));
      check("out_data", 32'(bus.out_data), 32'(e_data));
   endtask

   task automatic run(input int n);
      logic [9:0] word;
      repeat (n) begin
         next_word(word);
         tick(word);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_locked"}, 32'(bus.locked),   32'd0);
      check({tag, "_offset"}, 32'(bus.offset),   32'd0);
      check({tag, "_de"},     32'(bus.out_de),   32'd0);
      check({tag, "_c"},      32'(bus.out_c),    32'd0);
      check({tag, "_data"},   32'(bus.out_data), 32'd0);
   endtask

   initial begin
      toks[0] = 10'b1101010100;
      toks[1] = 10'b0010101011;
      toks[2] = 10'b0101010100;
      toks[3] = 10'b1010101011;
      for (int b = 0; b < 256; b++) begin
         for (int m = 0; m < 2; m++) begin
            logic [9:0] s;
            s = encode_byte(8'(b), 1'(m), 1'b0);
            dec_tab[{1'(m), s[7:0]}] = 8'(b);
         end
      end
      g_last      = '0;
      resetn      = 1'b1;
      bus.in_word = '0;
      model_reset();

      // Reset held with random input
      #2 resetn = 1'b0;
      repeat (6) tick(10'($urandom));
      check_zero("rst");
      resetn = 1'b1;

      // Aligned stream: blank 0x100 data, c=00 tokens
      start_stream(0, 1'b0, 1'b0, 1'b0);
      run(3 * LINE_LEN);
      check("aligned_locked", 32'(bus.locked), 32'd1);
      check("aligned_offset", 32'(bus.offset), 32'd0);

      // Random pixel data with mixed control classes
      start_stream(0, 1'b1, 1'b1, 1'b0);
      run(2 * LINE_LEN);

      // Directed control tokens, observed two clocks after input
      tick(toks[1]);
      tick(toks[2]);
      tick(toks[3]);
      check("ctl01_c",    32'(bus.out_c),    32'd1);
      check("ctl01_de",   32'(bus.out_de),   32'd0);
      check("ctl01_data", 32'(bus.out_data), 32'd0);
      tick(10'h100);
      check("ctl10_c", 32'(bus.out_c), 32'd2);
      tick(10'h100);
      check("ctl11_c", 32'(bus.out_c), 32'd3);
      tick(10'h100);
      check("data_de",   32'(bus.out_de),   32'd1);
      check("data_byte", 32'(bus.out_data), 32'd0);
      check("data_hold_c", 32'(bus.out_c),  32'd3);
      g_last = 10'h100;

      // Mid-lock asynchronous reset pulse
      check("prereset_locked", 32'(bus.locked), 32'd1);
      resetn = 1'b0;
      #1;
      model_reset();
      check_zero("async_rst");
      tick(10'($urandom));
      resetn = 1'b1;

      // Misaligned stream (3 bit delay) relocks after searching from offset 0
      g_last = '0;
      start_stream(3, 1'b0, 1'b0, 1'b0);
      run(11 * LINE_LEN);
      check("misal_locked", 32'(bus.locked), 32'd1);
      check("misal_offset", 32'(bus.offset), 32'd3);

      // Loss of lock: data only, no tokens
      start_stream(3, 1'b1, 1'b0, 1'b1);
      run(4400);
      check("loss_locked", 32'(bus.locked),   32'd0);
      check("loss_offset", 32'(bus.offset),   32'd4);
      check("loss_de",     32'(bus.out_de),   32'd0);
      check("loss_data",   32'(bus.out_data), 32'd0);

      // Tokens back at a different alignment: slips wrap 9->0 to offset 2
      start_stream(2, 1'b1, 1'b0, 1'b0);
      run(22 * LINE_LEN);
      check("relock_locked", 32'(bus.locked), 32'd1);
      check("relock_offset", 32'(bus.offset), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
